// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multicycle control path.
// Holds the FSM state encoding, opcode classes, opcode match constants/masks and the
// datapath mux/ALU control codes used by main_control_fsm and op_class_decode.
package legv8_pkg;

  // state_o exposes these encodings directly
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StExecR    = 4'd2,
    StWbR      = 4'd3,
    StMemAddr  = 4'd4,
    StMemRd    = 4'd5,
    StMemWr    = 4'd6,
    StWbLd     = 4'd7,
    StBrCond   = 4'd8,
    StBrUncond = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    OpR       = 3'd0,
    OpLd      = 3'd1,
    OpSt      = 3'd2,
    OpCbz     = 3'd3,
    OpB       = 3'd4,
    OpIllegal = 3'd5
  } op_class_e;

  // Full 11-bit opcodes
  localparam logic [10:0] OpcAdd  = 11'b10001011000;
  localparam logic [10:0] OpcSub  = 11'b11001011000;
  localparam logic [10:0] OpcAnd  = 11'b10001010000;
  localparam logic [10:0] OpcOrr  = 11'b10101010000;
  localparam logic [10:0] OpcLdur = 11'b11111000010;
  localparam logic [10:0] OpcStur = 11'b11111000000;

  // Short-opcode formats: match (opcode & mask) == value
  localparam logic [10:0] OpcCbz  = 11'b10110100000;
  localparam logic [10:0] MaskCbz = 11'b11111111000;
  localparam logic [10:0] OpcB    = 11'b00010100000;
  localparam logic [10:0] MaskB   = 11'b11111100000;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpPassB = 2'b01;
  localparam logic [1:0] AluOpRType = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBDImm  = 2'b10;
  localparam logic [1:0] SrcBBrImm = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode   in  11  instruction[31:21]
//   op_class out  3  R / LD / ST / CBZ / B / ILLEGAL
module op_class_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_e   op_class
);

  always_comb begin
    op_class = OpIllegal;
    if (opcode == OpcAdd || opcode == OpcSub || opcode == OpcAnd || opcode == OpcOrr) begin
      op_class = OpR;
    end else if (opcode == OpcLdur) begin
      op_class = OpLd;
    end else if (opcode == OpcStur) begin
      op_class = OpSt;
    end else if ((opcode & MaskCbz) == OpcCbz) begin
      op_class = OpCbz;
    end else if ((opcode & MaskB) == OpcB) begin
      op_class = OpB;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Moore control FSM for the LEGv8 multicycle datapath.
// Ports:
//   clk, rst (sync, active-high)
//   opcode     in  11  instruction[31:21], sampled only in DECODE and MEM_ADDR
//   mem_ready  in   1  memory completes current access (used in FETCH/MEM_RD/MEM_WR)
//   ALUOp/ALUSrcA/ALUSrcB/PCSource and single-bit datapath strobes  out
//   illegal_op out  1  pulses in DECODE for an unrecognised opcode
//   state_o    out  4  current state encoding (reads FETCH while rst=1)
module main_control_fsm
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        Reg2Loc,
  output logic        illegal_op,
  output logic [3:0]  state_o
);

  state_e    state_q, state_d;
  op_class_e op_class;

  op_class_decode u_op_class_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ALUOp       = AluOpAdd;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SrcBReg;
    PCSource    = PcSrcAlu;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    Reg2Loc     = 1'b0;
    illegal_op  = 1'b0;

    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBFour;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcB = SrcBBrImm;
        Reg2Loc = (op_class == OpSt) || (op_class == OpCbz);
        unique case (op_class)
          OpR:        state_d = StExecR;
          OpLd, OpSt: state_d = StMemAddr;
          OpCbz:      state_d = StBrCond;
          OpB:        state_d = StBrUncond;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluOpRType;
        state_d = StWbR;
      end
      StWbR: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBDImm;
        Reg2Loc = (op_class == OpSt);
        // Opcode changed under us since DECODE: abandon the instruction
        if (op_class == OpLd)      state_d = StMemRd;
        else if (op_class == OpSt) state_d = StMemWr;
        else                       state_d = StFetch;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = StWbLd;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StWbLd: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = StFetch;
      end
      StBrCond: begin
        ALUSrcA     = 1'b1;
        ALUOp       = AluOpPassB;
        PCWriteCond = 1'b1;
        PCSource    = PcSrcAluOut;
        Reg2Loc     = 1'b1;
        state_d     = StFetch;
      end
      StBrUncond: begin
        PCWrite  = 1'b1;
        PCSource = PcSrcAluOut;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset masks every output so nothing fires while the register is being cleared
    if (rst) begin
      ALUOp       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      Reg2Loc     = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  assign state_o = rst ? StFetch : state_q;

endmodule
